// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a one-byte holding register.
// Define UART_TX_PARITY_EN for an 8E1 frame (even parity before stop).
module uart_tx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    input  logic       clr_done,
    output logic       TX,
    output logic       tx_done,
    output logic       busy,
    output logic       hold_full
);

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_TERM = CW'(BAUD_DIV - 1);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    typedef enum logic {
        IDLE,
        TRANSMIT
    } state_t;

    state_t                state;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [CW-1:0]         baud_cnt;
    logic [3:0]            bit_cnt;
    logic [7:0]            hold_data;
    logic                  baud_tick;
    logic                  frame_end;
    logic                  hold_take;

    function automatic logic [FRAME_BITS-1:0] frame(
        input logic [7:0] d
    );
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    assign baud_tick = (state == TRANSMIT) &&
                       (baud_cnt == BAUD_TERM);
    assign frame_end = baud_tick && (bit_cnt == LAST_BIT);

    // A request landing on an empty-hold frame end restarts directly.
    assign hold_take = trmt && (state == TRANSMIT) &&
                       !hold_full && !frame_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            TX        <= 1'b1;
        end else begin
            if (clr_done) begin
                tx_done <= 1'b0;
            end
            if (hold_take) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (trmt) begin
                        state     <= TRANSMIT;
                        busy      <= 1'b1;
                        tx_done   <= 1'b0;
                        shift_reg <= frame(tx_data);
                        TX        <= 1'b0;
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                    end
                end
                TRANSMIT: begin
                    if (!baud_tick) begin
                        baud_cnt <= baud_cnt + CW'(1);
                        TX       <= shift_reg[0];
                    end else if (!frame_end) begin
                        baud_cnt  <= '0;
                        bit_cnt   <= bit_cnt + 4'd1;
                        shift_reg <= {1'b1,
                                      shift_reg[FRAME_BITS-1:1]};
                        TX        <= shift_reg[1];
                    end else begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        if (hold_full) begin
                            shift_reg <= frame(hold_data);
                            hold_full <= 1'b0;
                            TX        <= 1'b0;
                        end else if (trmt) begin
                            shift_reg <= frame(tx_data);
                            TX        <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            tx_done <= 1'b1;
                            TX      <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx with a short bit period.
// Honours UART_TX_PARITY_EN to check the 8E1 frame.
module tb_uart_tx;

    localparam int BD = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME_CLKS = NB * BD;
    localparam int LIMIT = 3 * FRAME_CLKS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trmt = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       clr_done = 1'b0;
    logic       TX;
    logic       tx_done;
    logic       busy;
    logic       hold_full;

    uart_tx #(
        .BAUD_DIV(BD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .clr_done (clr_done),
        .TX       (TX),
        .tx_done  (tx_done),
        .busy     (busy),
        .hold_full(hold_full)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         passed = 0;
    int         rx_frames = 0;
    logic [7:0] exp_q[$];

    // Line receiver: pops the expected byte at each start bit and
    // compares TX and busy on every cycle of the frame.
    bit          mon_active = 0;
    int          mon_cyc;
    int          mon_bad;
    logic        mon_bad_tx;
    logic        mon_bad_busy;
    logic [7:0]  mon_byte;
    logic [10:0] mon_frame;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 0;
        end else if (!mon_active && TX === 1'b0) begin
            mon_active = 1;
            mon_cyc = 0;
            mon_bad = -1;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_frame: start bit with empty queue");
                mon_byte = 8'hxx;
                mon_frame = '1;
            end else begin
                mon_byte = exp_q.pop_front();
`ifdef UART_TX_PARITY_EN
                mon_frame = {1'b1, ^mon_byte, mon_byte, 1'b0};
`else
                mon_frame = {2'b11, mon_byte, 1'b0};
`endif
            end
        end
        if (mon_active) begin
            if ((TX !== mon_frame[mon_cyc / BD] || busy !== 1'b1)
                && mon_bad < 0) begin
                mon_bad = mon_cyc;
                mon_bad_tx = TX;
                mon_bad_busy = busy;
            end
            if (mon_cyc == FRAME_CLKS - 1) begin
                checks++;
                if (mon_bad >= 0)
                    $display("FAIL frame_%02h: cycle %0d TX=%b busy=%b want TX=%b busy=1",
                             mon_byte, mon_bad, mon_bad_tx, mon_bad_busy,
                             mon_frame[mon_bad / BD]);
                else
                    passed++;
                rx_frames++;
                mon_active = 0;
            end else begin
                mon_cyc++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit push);
        @(negedge clk);
        tx_data = b;
        trmt = 1'b1;
        if (push) exp_q.push_back(b);
        @(negedge clk);
        trmt = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (tx_done !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (TX !== 1'b1) $display("FAIL reset_tx: got %b want 1", TX);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else passed++;
        checks++;
        if (hold_full !== 1'b0) $display("FAIL reset_hold: got %b want 0", hold_full);
        else passed++;
        checks++;
        if (tx_done !== 1'b0) $display("FAIL reset_done: got %b want 0", tx_done);
        else passed++;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (TX !== 1'b1 || busy !== 1'b0)
            $display("FAIL idle_after_reset: TX=%b busy=%b want 1/0", TX, busy);
        else passed++;
    endtask

    task automatic test_basic;
        bit pat [11];
        int done_at;
        int f0;
        bit busy_bad;
`ifdef UART_TX_PARITY_EN
        pat = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        pat = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif
        f0 = rx_frames;
        done_at = -1;
        busy_bad = 0;
        @(negedge clk);
        tx_data = 8'hA5;
        trmt = 1'b1;
        exp_q.push_back(8'hA5);
        checks++;
        if (TX !== 1'b1) $display("FAIL pre_start_tx: got %b want 1", TX);
        else passed++;
        @(negedge clk);
        trmt = 1'b0;
        for (int n = 0; n < FRAME_CLKS + 2 * BD; n++) begin
            if (n == 0) begin
                checks++;
                if (TX !== 1'b0) $display("FAIL start_latency: got %b want 0", TX);
                else passed++;
            end
            if (n < FRAME_CLKS && n % BD == BD / 2) begin
                checks++;
                if (TX !== pat[n / BD])
                    $display("FAIL a5_bit%0d: got %b want %b", n / BD, TX, pat[n / BD]);
                else passed++;
            end
            if (n < FRAME_CLKS && busy !== 1'b1) busy_bad = 1;
            if (tx_done === 1'b1 && done_at < 0) done_at = n;
            @(negedge clk);
        end
        checks++;
        if (done_at != FRAME_CLKS)
            $display("FAIL a5_done_time: got %0d want %0d", done_at, FRAME_CLKS);
        else passed++;
        checks++;
        if (busy_bad) $display("FAIL a5_busy: got busy low in frame want 1");
        else passed++;
        checks++;
        if (rx_frames - f0 != 1)
            $display("FAIL a5_frames: got %0d want 1", rx_frames - f0);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int done_at;
        int hold_clr;
        int f0;
        f0 = rx_frames;
        done_at = -1;
        hold_clr = -1;
        send_byte(8'h3C, 1);
        for (int n = 0; n < 2 * FRAME_CLKS + 2 * BD; n++) begin
            if (n == 3 * BD) begin
                tx_data = 8'hC3;
                trmt = 1'b1;
                exp_q.push_back(8'hC3);
            end
            if (n == 3 * BD + 1) begin
                trmt = 1'b0;
                checks++;
                if (hold_full !== 1'b1) $display("FAIL hold_set: got %b want 1", hold_full);
                else passed++;
            end
            if (n == 4 * BD) begin
                tx_data = 8'hFF;
                trmt = 1'b1;
            end
            if (n == 4 * BD + 1) begin
                trmt = 1'b0;
                checks++;
                if (hold_full !== 1'b1) $display("FAIL hold_drop: got %b want 1", hold_full);
                else passed++;
            end
            if (n > 3 * BD + 1 && hold_full === 1'b0 && hold_clr < 0) hold_clr = n;
            if (tx_done === 1'b1 && done_at < 0) done_at = n;
            @(negedge clk);
        end
        checks++;
        if (hold_clr != FRAME_CLKS)
            $display("FAIL hold_clear_time: got %0d want %0d", hold_clr, FRAME_CLKS);
        else passed++;
        checks++;
        if (done_at != 2 * FRAME_CLKS)
            $display("FAIL b2b_done_time: got %0d want %0d", done_at, 2 * FRAME_CLKS);
        else passed++;
        checks++;
        if (rx_frames - f0 != 2)
            $display("FAIL b2b_frames: got %0d want 2", rx_frames - f0);
        else passed++;
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL b2b_queue: got %0d left want 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_done_collision;
        int done_at;
        int f0;
        f0 = rx_frames;
        done_at = -1;
        send_byte(8'h12, 1);
        for (int n = 0; n < 2 * FRAME_CLKS + 2 * BD; n++) begin
            if (n == FRAME_CLKS - 1) begin
                tx_data = 8'h34;
                trmt = 1'b1;
                exp_q.push_back(8'h34);
            end
            if (n == FRAME_CLKS) begin
                trmt = 1'b0;
                checks++;
                if (tx_done !== 1'b0 || hold_full !== 1'b0 ||
                    busy !== 1'b1 || TX !== 1'b0)
                    $display("FAIL collide_restart: done=%b hold=%b busy=%b TX=%b want 0/0/1/0",
                             tx_done, hold_full, busy, TX);
                else passed++;
            end
            if (tx_done === 1'b1 && done_at < 0) done_at = n;
            @(negedge clk);
        end
        checks++;
        if (done_at != 2 * FRAME_CLKS)
            $display("FAIL collide_done_time: got %0d want %0d", done_at, 2 * FRAME_CLKS);
        else passed++;
        checks++;
        if (rx_frames - f0 != 2)
            $display("FAIL collide_frames: got %0d want 2", rx_frames - f0);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int n;
        int f0;
        send_byte(8'h00, 1);
        repeat (BD) @(negedge clk);
        tx_data = 8'h55;
        trmt = 1'b1;
        exp_q.push_back(8'h55);
        @(negedge clk);
        trmt = 1'b0;
        repeat (3 * BD + BD / 2 - 1) @(negedge clk);
        checks++;
        if (TX !== 1'b0 || hold_full !== 1'b1)
            $display("FAIL mid_bit4: TX=%b hold=%b want 0/1", TX, hold_full);
        else passed++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (TX !== 1'b1) $display("FAIL async_tx: got %b want 1", TX);
        else passed++;
        checks++;
        if (busy !== 1'b0 || hold_full !== 1'b0 || tx_done !== 1'b0)
            $display("FAIL async_flags: busy=%b hold=%b done=%b want 0/0/0",
                     busy, hold_full, tx_done);
        else passed++;
        exp_q.delete();
        f0 = rx_frames;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        send_byte(8'h81, 1);
        wait_done(n);
        checks++;
        if (n != FRAME_CLKS)
            $display("FAIL post_reset_done_time: got %0d want %0d", n, FRAME_CLKS);
        else passed++;
        checks++;
        if (rx_frames - f0 != 1)
            $display("FAIL post_reset_frames: got %0d want 1", rx_frames - f0);
        else passed++;
    endtask

    task automatic test_clr_done;
        int n;
        @(negedge clk);
        checks++;
        if (tx_done !== 1'b1) $display("FAIL done_sticky: got %b want 1", tx_done);
        else passed++;
        clr_done = 1'b1;
        @(negedge clk);
        clr_done = 1'b0;
        checks++;
        if (tx_done !== 1'b0 || TX !== 1'b1)
            $display("FAIL clr_done: done=%b TX=%b want 0/1", tx_done, TX);
        else passed++;
        send_byte(8'h5A, 1);
        wait_done(n);
        checks++;
        if (n != FRAME_CLKS)
            $display("FAIL 5a_done_time: got %0d want %0d", n, FRAME_CLKS);
        else passed++;
        @(negedge clk);
        tx_data = 8'h96;
        trmt = 1'b1;
        clr_done = 1'b1;
        exp_q.push_back(8'h96);
        @(negedge clk);
        trmt = 1'b0;
        clr_done = 1'b0;
        checks++;
        if (tx_done !== 1'b0 || busy !== 1'b1)
            $display("FAIL trmt_and_clr: done=%b busy=%b want 0/1", tx_done, busy);
        else passed++;
        repeat (BD) @(negedge clk);
        clr_done = 1'b1;
        @(negedge clk);
        clr_done = 1'b0;
        wait_done(n);
        checks++;
        if (BD + 1 + n != FRAME_CLKS)
            $display("FAIL clr_busy_done_time: got %0d want %0d", BD + 1 + n, FRAME_CLKS);
        else passed++;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [7:0] d [2];
        bit         p [2];
        int         n;
        d = '{8'h07, 8'h03};
        p = '{1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            send_byte(d[k], 1);
            repeat (9 * BD + BD / 2) @(negedge clk);
            checks++;
            if (TX !== p[k])
                $display("FAIL parity_%02h: got %b want %b", d[k], TX, p[k]);
            else passed++;
            wait_done(n);
            checks++;
            if (9 * BD + BD / 2 + n != 11 * BD)
                $display("FAIL parity_len_%02h: got %0d want %0d",
                         d[k], 9 * BD + BD / 2 + n, 11 * BD);
            else passed++;
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_done_collision();
        test_reset_mid();
        test_clr_done();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        repeat (2 * BD) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || TX !== 1'b1)
            $display("FAIL scoreboard_end: left=%0d TX=%b want 0/1", exp_q.size(), TX);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter, the transmit-side counterpart of the design's 19200-baud UART receiver.
- Runs on the 50 MHz system clock.
- Serialises a byte onto TX, LSB first, framed by start/stop bits.
- Holds one pending byte so the host can queue the next frame while the current one shifts out; back-to-back frames go out with no idle gap.

Parameters:
BAUD_DIV, 2604, clocks per bit (50 MHz / 19200); must be >= 4; bit-period counter width = $clog2(BAUD_DIV).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
trmt  input  1  one-cycle request to send tx_data
tx_data  input  8  byte to send; sampled on the cycle trmt is accepted
clr_done  input  1  clears tx_done
TX  output  1  serial line, idle high
tx_done  output  1  sticky: last frame finished and nothing pending
busy  output  1  frame in progress (state TRANSMIT)
hold_full  output  1  pending byte held; trmt ignored while high

Behaviour:
- Reset (async, rst=1): TX=1, tx_done=0, busy=0, hold_full=0, state=IDLE. Counters and shift register are cleared. A frame in flight is abandoned, and TX returns high immediately, without waiting for a clock edge.
- Frame: start(0), d[0]..d[7], stop(1). That is 10 bit-times of BAUD_DIV clocks each, 26040 clocks at the default.
- Shift register is 10 bits, {1'b1, data, 1'b0}, shifted right. TX is driven from the register's LSB through a flop, so TX is glitch-free.
- States IDLE and TRANSMIT:
  - IDLE, trmt=1: load the shift register from tx_data, clear tx_done, go to TRANSMIT. TX falls on the clock edge after the trmt cycle (latency 1).
  - TRANSMIT: the baud counter counts up 0..BAUD_DIV-1. At terminal count: shift, increment bit_cnt, clear the baud counter.
  - When bit_cnt reaches 10 (end of the stop bit), the frame is complete:
    - hold_full=1: reload from the holding register, clear hold_full and bit_cnt, stay in TRANSMIT. The next start bit follows the stop bit with no extra cycle.
    - hold_full=0: go to IDLE and set tx_done.
- Holding register:
  - trmt in TRANSMIT with hold_full=0: capture tx_data, set hold_full.
  - trmt with hold_full=1: ignored; the byte is dropped and no state changes.
- Simultaneous events:
  - trmt on the same cycle a frame completes with hold empty: treated as an IDLE-start. The frame begins next cycle, tx_done stays 0, hold_full stays 0.
  - trmt and clr_done together: tx_done=0.
  - clr_done while busy: no effect (tx_done is already 0).
- tx_done is cleared by clr_done, or by any accepted trmt.
- bit_cnt is 4 bits; the baud counter never wraps past BAUD_DIV-1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Frame is 8E1: start, d[0..7], even-parity bit (XOR of d), stop. 11 bit-times.
  - Shift register is 11 bits; completion at bit_cnt==11.
  - Parity is computed when the byte is loaded (IDLE start or holding reload).
- Undefined: 8N1 exactly as above; no parity logic is present.

Test Plan:
- Reset, then trmt with tx_data=0xA5. TX=1 until one cycle after trmt, then 0,1,0,1,0,0,1,0,1,1, each bit held 2604 clocks. tx_done rises 26040 clocks after TX falls; busy=1 throughout the frame.
- Send 0x3C, then trmt 0xC3 mid-frame. hold_full=1 until the first stop bit ends. The second start bit begins on the cycle after the first stop bit ends. tx_done stays 0 until the second frame ends (52080 clocks total).
- Frame active and hold_full=1, third trmt with 0xFF. 0xFF never appears on TX; only the two queued bytes are sent.
- Assert rst mid-frame (bit 4 of 0x00). TX=1 asynchronously; busy, hold_full and tx_done all 0. A fresh trmt 0x81 then sends a correct full frame.
- tx_done=1, pulse clr_done. tx_done=0 next cycle, TX stays 1. A new trmt on the same cycle as clr_done also leaves tx_done=0.
- With UART_TX_PARITY_EN: tx_data=0x07 gives parity bit 1 and an 11-bit frame (28644 clocks); tx_data=0x03 gives parity bit 0.
